// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-function and x8-source encodings plus the packed control bundle
// passed from the combinational decoder to the registered pipeline stage.
package ctrl_pkg;

    localparam logic [3:0] OP_LI  = 4'd0;
    localparam logic [3:0] OP_JA  = 4'd1;
    localparam logic [3:0] OP_BEZ = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_LR  = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SR  = 4'd6;
    localparam logic [3:0] OP_SUB = 4'd8;
    localparam logic [3:0] OP_AND = 4'd9;
    localparam logic [3:0] OP_OR  = 4'd10;
    localparam logic [3:0] OP_XOR = 4'd11;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_NOT = 3'd1,
        ALU_SUB = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_XOR = 3'd5
    } alu_fun_e;

    typedef enum logic [1:0] {
        X8_REG = 2'd0,
        X8_IMM = 2'd1,
        X8_ALU = 2'd2
    } x8_sel_e;

    typedef struct packed {
        logic     bez;
        logic     ja;
        logic     op1;
        logic     op2;
        alu_fun_e alu_fun;
        logic     write_reg;
        logic     write_x8;
        x8_sel_e  x8_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Combinational opcode-to-control decoder; OPW=3 reproduces the legacy map exactly,
// OPW=4 adds the sub/and/or/xor rows built on the add row.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int OPW = 3
) (
    input  logic [OPW-1:0] i_opcode,
    output ctrl_t          o_ctrl,
    output logic           o_illegal
);

    logic [3:0] w_op;

    assign w_op = 4'(i_opcode);

    always_comb begin
        o_ctrl    = CTRL_NOP;
        o_illegal = 1'b0;
        case (w_op)
            OP_LI: begin
                o_ctrl.write_x8 = 1'b1;
                o_ctrl.x8_sel   = X8_IMM;
            end
            OP_JA: begin
                o_ctrl.ja  = 1'b1;
                o_ctrl.op1 = 1'b1;
                o_ctrl.op2 = 1'b1;
            end
            OP_BEZ: begin
                o_ctrl.bez = 1'b1;
                o_ctrl.op2 = 1'b1;
            end
            OP_ADD: begin
                o_ctrl.op1      = 1'b1;
                o_ctrl.write_x8 = 1'b1;
                o_ctrl.x8_sel   = X8_ALU;
            end
            OP_LR: begin
                o_ctrl.write_x8 = 1'b1;
                o_ctrl.x8_sel   = X8_REG;
            end
            OP_NOT: begin
                o_ctrl.op1      = 1'b1;
                o_ctrl.alu_fun  = ALU_NOT;
                o_ctrl.write_x8 = 1'b1;
                o_ctrl.x8_sel   = X8_ALU;
            end
            OP_SR: begin
                o_ctrl.write_reg = 1'b1;
            end
            OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                // Only reachable when OPW=4; the upper opcode bit is zero otherwise.
                if (OPW == 4) begin
                    o_ctrl.op1      = 1'b1;
                    o_ctrl.write_x8 = 1'b1;
                    o_ctrl.x8_sel   = X8_ALU;
                    case (w_op)
                        OP_SUB:  o_ctrl.alu_fun = ALU_SUB;
                        OP_AND:  o_ctrl.alu_fun = ALU_AND;
                        OP_OR:   o_ctrl.alu_fun = ALU_OR;
                        default: o_ctrl.alu_fun = ALU_XOR;
                    endcase
                end else begin
                    o_illegal = 1'b1;
                end
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered control decoder stage: valid/ready handshake, flush with a branch-shadow
// drop counter, and a sticky error flag for issued illegal opcodes.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int OPW    = 3,
    parameter int SHADOW = 1,
    parameter int CW     = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_opcode,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           bez,
    output logic           ja,
    output logic [2:0]     alu_fun,
    output logic           op1,
    output logic           op2,
    output logic           write_reg,
    output logic           write_x8,
    output logic [1:0]     x8_sel,
    output logic           illegal,
    output logic           err,
    input  logic           err_clr
);

    ctrl_t          w_ctrl;
    logic           w_illegal;
    logic           w_in_shadow;
    logic           w_accept;
    logic           w_err_set;

    ctrl_t          r_ctrl;
    logic           r_illegal;
    logic           r_valid;
    logic           r_err;
    logic [CW-1:0]  r_shadow;

    ctrl_decode_comb #(
        .OPW (OPW)
    ) u_dec (
        .i_opcode  (in_opcode),
        .o_ctrl    (w_ctrl),
        .o_illegal (w_illegal)
    );

    assign w_in_shadow = (r_shadow != '0);
    // During the shadow the stage is always ready so fetch can drain wrong-path work.
    assign in_ready    = !reset && (w_in_shadow || !r_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_err_set   = r_valid && r_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_ctrl    <= CTRL_NOP;
            r_illegal <= 1'b0;
            r_shadow  <= '0;
        end else if (flush) begin
            r_valid   <= 1'b0;
            r_ctrl    <= CTRL_NOP;
            r_illegal <= 1'b0;
            r_shadow  <= CW'(SHADOW);
        end else if (w_accept && w_in_shadow) begin
            r_shadow  <= r_shadow - CW'(1);
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_ctrl    <= w_ctrl;
            r_illegal <= w_illegal;
        end else if (out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign bez       = r_ctrl.bez;
    assign ja        = r_ctrl.ja;
    assign alu_fun   = r_ctrl.alu_fun;
    assign op1       = r_ctrl.op1;
    assign op2       = r_ctrl.op2;
    assign write_reg = r_ctrl.write_reg;
    assign write_x8  = r_ctrl.write_x8;
    assign x8_sel    = r_ctrl.x8_sel;
    assign illegal   = r_illegal;
    assign err       = r_err;

endmodule
